// File: rtl/fetch_queue_unit_pkg.sv
// Shared fetch-stage helpers: PC step size and redirect alignment mask.
// Latency: none, constants and pure functions only.
// Backpressure: not applicable.
package fetch_queue_unit_pkg;

    // Widest address the alignment helper can produce a mask for.
    localparam int FQ_MAX_ADDR_WIDTH = 64;

    // Bytes the PC advances per fetched word.
    function automatic int byteInc(input int dataWidth);
        return dataWidth / 8;
    endfunction

    // Mask that clears the byte-offset bits of a word-aligned address.
    function automatic logic [FQ_MAX_ADDR_WIDTH-1:0] alignMask(input int bytesPerWord);
        return ~(FQ_MAX_ADDR_WIDTH'(bytesPerWord) - FQ_MAX_ADDR_WIDTH'(1));
    endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// Generic synchronous FIFO with flush, used for the fetch queue and the request-tag FIFO.
// Latency: a pushed entry is visible at the head the cycle after its push edge.
// Backpressure: a push into a full FIFO without a same-cycle pop is dropped; owners hold credit instead.
module fetch_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       headData,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPop    = pop && (count != '0);
    assign doPush   = push && ((count != CNT_W'(DEPTH)) || doPop);
    assign headData = mem[rdPtr];

    // Storage array: written on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers and occupancy; flush empties the FIFO and overrides any push/pop.
    always_ff @(posedge clk) begin
        if (!resetN || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch front end with prefetch queue; FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect fault.
// Latency: a response accepted at edge N is presented to decode after edge N; redirect refetches from edge N+1.
// Backpressure: decode stalls via outReady; issue is credit-limited so every response has a queue slot.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirectPc,
    output logic                  reqValid,
    input  logic                  reqReady,
    output logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic                  respValid,
    input  logic [DATA_WIDTH-1:0] respData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] outInstr,
    output logic [ADDR_WIDTH-1:0] outPc,
    output logic                  fault
);

    localparam int                    CNT_W        = $clog2(DEPTH) + 1;
    localparam int                    BYTE_INC     = byteInc(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP      = ADDR_WIDTH'(BYTE_INC);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK   = ADDR_WIDTH'(alignMask(BYTE_INC));
    localparam logic [CNT_W:0]        CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetchEntry_t;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] redirectTarget;
    logic [ADDR_WIDTH-1:0] tagHead;
    logic [CNT_W-1:0]      dropCount;
    logic [CNT_W-1:0]      tagCount;
    logic [CNT_W-1:0]      queueCount;
    logic [CNT_W-1:0]      outstanding;
    fetchEntry_t           queueHead;
    fetchEntry_t           queuePushEntry;
    logic                  issue;
    logic                  respLive;
    logic                  respKeep;

    // Every in-flight request is either still tagged (live) or marked stale, so
    // the outstanding count is derived rather than kept as a separate register.
    assign outstanding = tagCount + dropCount;

    // Credit counts stale requests too: it is conservative but never overflows the queue.
    assign reqValid = resetN && !redirect && !fault &&
                      (({1'b0, outstanding} + {1'b0, queueCount}) < CREDIT_LIMIT);
    assign reqAddr  = pc;
    assign issue    = reqValid && reqReady;

    // A response with nothing in flight is ignored so the counters cannot underflow.
    assign respLive = respValid && (outstanding != '0);
    assign respKeep = respLive && !redirect && (dropCount == '0);

    assign queuePushEntry = '{pc: tagHead, instr: respData};

    assign outValid = (queueCount != '0);
    assign outInstr = queueHead.instr;
    assign outPc    = queueHead.pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirectTarget = redirectPc;

    // Misaligned redirect latches a fault that blocks issue until reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            fault <= 1'b0;
        end else if (redirect && (|(redirectPc & ~ALIGN_MASK))) begin
            fault <= 1'b1;
        end
    end
`else
    assign redirectTarget = redirectPc & ALIGN_MASK;
    assign fault          = 1'b0;
`endif

    // PC and stale-response bookkeeping; redirect wins over issue and response.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            pc        <= RESET_VECTOR;
            dropCount <= '0;
        end else if (redirect) begin
            pc        <= redirectTarget;
            dropCount <= outstanding - CNT_W'(respLive);
        end else begin
            if (issue) begin
                pc <= pc + PC_STEP;
            end
            if (respLive && (dropCount != '0)) begin
                dropCount <= dropCount - CNT_W'(1);
            end
        end
    end

    fetch_sync_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) tagFifo (
        .clk      (clk),
        .resetN   (resetN),
        .push     (issue),
        .pushData (pc),
        .pop      (respKeep),
        .flush    (redirect),
        .headData (tagHead),
        .count    (tagCount)
    );

    fetch_sync_fifo #(
        .WIDTH ($bits(fetchEntry_t)),
        .DEPTH (DEPTH)
    ) fetchQueue (
        .clk      (clk),
        .resetN   (resetN),
        .push     (respKeep),
        .pushData (queuePushEntry),
        .pop      (outReady && !redirect),
        .flush    (redirect),
        .headData (queueHead),
        .count    (queueCount)
    );

endmodule
